signal_sampler: RTL and testbench

SIGNAL_SAMPLER -- requirements
Module: signal_sampler

---
 rtl/sampler_pkg.sv | 15 +
 rtl/signal_sampler.sv | 115 +++++++++++
 tb/tb_signal_sampler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the signal sampler: state encoding and
// the DUT interface widths.
package sampler_pkg;

    localparam int DUT_WIDTH    = 32;
    localparam int SELECT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/signal_sampler.sv
// Drives a stimulus word into an external DUT, sweeps its bit-select output one
// bit at a time with a settle delay per bit, and returns the assembled word.
module signal_sampler
    import sampler_pkg::*;
#(
    parameter int NUM_SIGNALS   = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DUT_WIDTH-1:0] req_vector,
    output logic [DUT_WIDTH-1:0] dut_input,
    output logic [DUT_WIDTH-1:0] dut_signal_select,
    input  logic                 dut_output,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DUT_WIDTH-1:0] rsp_data
);

    localparam logic [SELECT_WIDTH-1:0] SEL_LAST    = SELECT_WIDTH'(NUM_SIGNALS - 1);
    localparam logic [3:0]              SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    // With no settle time every bit goes straight to its sample cycle.
    localparam state_e                  BIT_START   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_e                  state_q,     state_d;
    logic [3:0]              cnt_q,       cnt_d;
    logic [SELECT_WIDTH-1:0] sel_q,       sel_d;
    logic [DUT_WIDTH-1:0]    din_q,       din_d;
    logic [DUT_WIDTH-1:0]    data_q,      data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    req_ready_q, req_ready_d;

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        din_d   = din_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    din_d   = req_vector;
                    sel_d   = {SELECT_WIDTH{1'b0}};
                    data_d  = {DUT_WIDTH{1'b0}};
                    cnt_d   = 4'd0;
                    state_d = BIT_START;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                data_d[sel_q] = dut_output;
                if (sel_q < SEL_LAST) begin
                    sel_d   = sel_q + {{(SELECT_WIDTH-1){1'b0}}, 1'b1};
                    cnt_d   = 4'd0;
                    state_d = BIT_START;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are registered from the next state so they line up with it.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sel_q       <= {SELECT_WIDTH{1'b0}};
            din_q       <= {DUT_WIDTH{1'b0}};
            data_q      <= {DUT_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            din_q       <= din_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = data_q;
    assign dut_input         = din_q;
    assign dut_signal_select = {{(DUT_WIDTH-SELECT_WIDTH){1'b0}}, sel_q};

endmodule

// File: tb/tb_signal_sampler.sv
// Scoreboard bench for signal_sampler, using an adder (high half + low half)
// as the DUT being swept.
module tb_signal_sampler;

    localparam int LAT_A = 32 * (2 + 1) + 1;
    localparam int LAT_B = 8 * (0 + 1) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, dut_output;
    logic [31:0] req_vector, dut_input, dut_signal_select, rsp_data, dut_sum;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_dut_output;
    logic [31:0] b_req_vector, b_dut_input, b_dut_signal_select, b_rsp_data, b_dut_sum;

    always #5 clk = ~clk;

    assign dut_sum      = {16'd0, dut_input[31:16]} + {16'd0, dut_input[15:0]};
    assign dut_output   = dut_sum[dut_signal_select[4:0]];
    assign b_dut_sum    = {16'd0, b_dut_input[31:16]} + {16'd0, b_dut_input[15:0]};
    assign b_dut_output = b_dut_sum[b_dut_signal_select[4:0]];

    signal_sampler u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_vector(req_vector), .dut_input(dut_input), .dut_signal_select(dut_signal_select),
        .dut_output(dut_output), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    signal_sampler #(.NUM_SIGNALS(8), .SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_vector(b_req_vector), .dut_input(b_dut_input), .dut_signal_select(b_dut_signal_select),
        .dut_output(b_dut_output), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          acc_log[$];
    int          hs_log[$];
    logic [31:0] last_rsp;

    // Reference: the word is the 17-bit sum of the halves, truncated to n bits.
    function automatic logic [31:0] model(input logic [31:0] v, input int n);
        logic [31:0] s;
        s = {16'd0, v[31:16]} + {16'd0, v[15:0]};
        if (n < 32) s = s & ((32'd1 << n) - 32'd1);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records acceptances into the scoreboard, checks responses and invariants.
    initial begin
        logic        prev_valid, prev_hs;
        logic [31:0] exp_din, held;
        int          a;
        prev_valid = 1'b0; prev_hs = 1'b0; exp_din = 32'd0; held = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0; prev_hs = 1'b0; exp_din = 32'd0;
                exp_q.delete(); acc_q.delete();
            end else begin
                chk("dut_input_stable", dut_input, exp_din);
                chk("select_upper_zero", {5'd0, dut_signal_select[31:5]}, 32'd0);
                if (prev_hs) begin
                    chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
                    chk("valid_drop_after_hs", {31'd0, rsp_valid}, 32'd0);
                end
                if (rsp_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp actual=0x%08h required=no response", rsp_data);
                    end else begin
                        held = exp_q.pop_front();
                        a = acc_q.pop_front();
                        last_rsp = rsp_data;
                        chk("rsp_data", rsp_data, held);
                        chk("rsp_latency", cyc - a, LAT_A);
                    end
                end else if (rsp_valid) begin
                    chk("rsp_data_hold", rsp_data, held);
                end
                if (rsp_valid) chk("req_ready_in_done", {31'd0, req_ready}, 32'd0);
                if (req_valid && req_ready) begin
                    exp_q.push_back(model(req_vector, 32));
                    acc_q.push_back(cyc);
                    acc_log.push_back(cyc);
                    exp_din = req_vector;
                end
                prev_hs = rsp_valid && rsp_ready;
                if (prev_hs) hs_log.push_back(cyc);
                prev_valid = rsp_valid && !rsp_ready;
            end
        end
    end

    task automatic send(input logic [31:0] v);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_vector = v;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 300) begin
                checks++; failures++;
                $display("FAIL accept_timeout actual=no accept required=accept");
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() == 0 && req_ready) break;
            n++;
            if (n > 600) begin
                checks++; failures++;
                $display("FAIL drain_timeout actual=busy required=idle");
                break;
            end
        end
        rsp_ready = 1'b1;
    endtask

    task automatic run_b(input logic [31:0] v);
        int n;
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_vector = v;
        @(negedge clk);
        chk("b_req_ready", {31'd0, b_req_ready}, 32'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (b_rsp_valid) break;
        end
        chk("b_latency", n, LAT_B);
        chk("b_rsp_data", b_rsp_data, model(v, 8));
        @(negedge clk);
        chk("b_ready_after_hs", {31'd0, b_req_ready}, 32'd1);
    endtask

    initial begin
        int a0, h0;
        logic [31:0] v;
        reset = 1'b1; req_valid = 1'b0; req_vector = 32'd0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_vector = 32'd0; b_rsp_ready = 1'b1;
        last_rsp = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_dut_input", dut_input, 32'd0);
        chk("rst_select", dut_signal_select, 32'd0);

        send(32'h0003_0005); drain(1'b0);
        chk("basic_sum", last_rsp, 32'h0000_0008);
        send(32'hFFFF_0001); drain(1'b0);
        chk("carry_bit16", last_rsp, 32'h0001_0000);

        // Consumer stalls for ten DONE cycles, accepting on the eleventh.
        rsp_ready = 1'b0;
        send(32'h1234_5678);
        for (int i = 0; i < 400 && !rsp_valid; i++) @(negedge clk);
        chk("stall_valid_seen", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("stall_valid_held", {31'd0, rsp_valid}, 32'd1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_valid_cycle11", {31'd0, rsp_valid}, 32'd1);
        drain(1'b0);
        chk("stall_data", last_rsp, model(32'h1234_5678, 32));

        // Reset partway through a sweep.
        send(32'h0003_0005);
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_dut_input", dut_input, 32'd0);
        chk("abort_select", dut_signal_select, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (110) @(negedge clk);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        send(32'h0003_0005); drain(1'b0);
        chk("after_abort_sum", last_rsp, 32'h0000_0008);

        // Two requests back to back with req_valid held high.
        a0 = acc_log.size(); h0 = hs_log.size();
        @(posedge clk); #1 req_valid = 1'b1; req_vector = 32'h00A0_0B00;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 req_vector = 32'h7FFF_8001;
        for (int i = 0; i < 400 && acc_log.size() < a0 + 2; i++) @(negedge clk);
        @(posedge clk); #1 req_valid = 1'b0;
        drain(1'b0);
        chk("b2b_data2", last_rsp, 32'h0001_0000);
        if (acc_log.size() >= a0 + 2 && hs_log.size() >= h0 + 1)
            chk("b2b_gap", acc_log[a0+1] - hs_log[h0], 1);
        else begin
            checks++; failures++;
            $display("FAIL b2b_count actual=%0d required=%0d", acc_log.size() - a0, 2);
        end

        for (int k = 0; k < 6; k++) begin
            v = $urandom;
            send(v); drain(1'b1);
        end

        run_b(32'h00FF_0001);
        chk("b_low8_zero", b_rsp_data, 32'h0000_0000);
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            run_b(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
